// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: N-channel memory-bus arbiter with registered grants, RR/fixed priority, lock and hold limit
// Ports:
//   i_clk, i_rstn                  clock, async active-low reset
//   i_reqAddr/i_reqWr/i_reqEn      per-channel address, write strobe, access request
//   i_reqLock                      per-channel hold-bus request (honoured while granted)
//   i_isBooted/i_isPaused          MCU state selecting which channels may own the bus
//   i_disableDrive                 boundary scan owns the pins; arbiter freezes and floats the bus
//   o_grant/o_ack/o_busy           registered one-hot grant, per-channel access ack, grant active
//   io_memAddr/io_memWr/io_memEn   memory bus pins
module mem_bus_arbiter #(
  parameter int NUM_CH   = 4,
  parameter int ADDR_W   = 16,
  parameter int MODE_RR  = 1,
  parameter int HOLD_MAX = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic [NUM_CH*ADDR_W-1:0] i_reqAddr,
  input  logic [NUM_CH-1:0]        i_reqWr,
  input  logic [NUM_CH-1:0]        i_reqEn,
  input  logic [NUM_CH-1:0]        i_reqLock,
  input  logic                     i_isBooted,
  input  logic                     i_isPaused,
  input  logic                     i_disableDrive,
  output logic [NUM_CH-1:0]        o_grant,
  output logic [NUM_CH-1:0]        o_ack,
  output logic                     o_busy,
  inout  wire  [ADDR_W-1:0]        io_memAddr,
  inout  wire                      io_memWr,
  inout  wire                      io_memEn
);
  localparam int IW = $clog2(NUM_CH);
  localparam int CW = $clog2(HOLD_MAX + 1);
  localparam logic [NUM_CH-1:0] MASK_BOOT = NUM_CH'(1);
  localparam logic [NUM_CH-1:0] MASK_JTAG = MASK_BOOT << (NUM_CH - 1);
  localparam logic [NUM_CH-1:0] MASK_RUN  = ~(MASK_BOOT | MASK_JTAG);
  typedef enum logic {IDLE, OWN} state_e;
  state_e            state_q;
  logic [NUM_CH-1:0] grant_q;
  logic [IW-1:0]     ptr_q;
  logic [CW-1:0]     cnt_q;
  logic [NUM_CH-1:0] mask, elig, acc, cand;
  logic [CW-1:0]     cnt_inc;
  logic              keep_g, locked, others, expire, rearb, arb, win_vld;
  logic [IW-1:0]     win;
  logic [ADDR_W-1:0] addr_mux;
  int                off;
  assign mask    = !i_isBooted ? MASK_BOOT : i_isPaused ? MASK_JTAG : MASK_RUN;
  assign elig    = i_reqEn & mask;
  assign acc     = grant_q & i_reqEn & {NUM_CH{!i_disableDrive}};
  // Hold limit is judged on the count including the access happening this cycle
  assign cnt_inc = (cnt_q == CW'(HOLD_MAX)) ? cnt_q : cnt_q + 1'b1;
  assign expire  = cnt_inc == CW'(HOLD_MAX);
  assign keep_g  = |(grant_q & elig);
  assign locked  = |(grant_q & i_reqLock);
  assign others  = |(elig & ~grant_q);
  assign rearb   = keep_g && !locked && expire && others;
  // Losing eligibility (mask or request) always releases, lock notwithstanding
  assign arb     = !keep_g || rearb;
  assign cand    = (MODE_RR != 0 && rearb) ? elig & ~grant_q : elig;
  assign off     = (MODE_RR != 0) ? int'(ptr_q) + 1 : 0;
  // Scan from the farthest candidate back so the first one after the start point wins
  always_comb begin
    win = '0;
    win_vld = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (cand[IW'((off + k) % NUM_CH)]) begin
        win = IW'((off + k) % NUM_CH);
        win_vld = 1'b1;
      end
  end
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= IW'(NUM_CH - 1);
      cnt_q   <= '0;
    end else if (!i_disableDrive) begin
      if (arb) begin
        state_q <= win_vld ? OWN : IDLE;
        grant_q <= win_vld ? MASK_BOOT << win : '0;
        ptr_q   <= win_vld ? win : ptr_q;
        cnt_q   <= '0;
      end else if (!locked) begin
        cnt_q <= cnt_inc;
      end
    end
  always_comb begin
    addr_mux = '0;
    for (int i = 0; i < NUM_CH; i++)
      addr_mux = addr_mux | (acc[i] ? i_reqAddr[i*ADDR_W +: ADDR_W] : '0);
  end
  assign o_grant    = grant_q;
  assign o_ack      = acc;
  assign o_busy     = state_q == OWN;
  assign io_memAddr = i_disableDrive ? 'z : addr_mux;
  assign io_memWr   = i_disableDrive ? 1'bz : |(acc & i_reqWr);
  assign io_memEn   = i_disableDrive ? 1'bz : |acc;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: randomized and directed checks of RR and fixed-priority arbiters against a reference model
module tb_mem_bus_arbiter;
  localparam int N  = 4;
  localparam int AW = 16;
  logic clk = 1'b0;
  logic rstn;
  logic [N*AW-1:0] addr;
  logic [N-1:0] wr, en, lk;
  logic booted, paused, dis;
  logic [N-1:0] grant_r, ack_r, grant_f, ack_f;
  logic busy_r, busy_f;
  wire [AW-1:0] maddr_r, maddr_f;
  wire mwr_r, men_r, mwr_f, men_f;
  int n_chk = 0;
  int n_err = 0;
  int mg[2], mp[2], mc[2];
  mem_bus_arbiter #(.NUM_CH(N), .ADDR_W(AW), .MODE_RR(1), .HOLD_MAX(2)) u_rr (
    .i_clk(clk), .i_rstn(rstn), .i_reqAddr(addr), .i_reqWr(wr), .i_reqEn(en), .i_reqLock(lk),
    .i_isBooted(booted), .i_isPaused(paused), .i_disableDrive(dis),
    .o_grant(grant_r), .o_ack(ack_r), .o_busy(busy_r),
    .io_memAddr(maddr_r), .io_memWr(mwr_r), .io_memEn(men_r));
  mem_bus_arbiter #(.NUM_CH(N), .ADDR_W(AW), .MODE_RR(0), .HOLD_MAX(1)) u_fx (
    .i_clk(clk), .i_rstn(rstn), .i_reqAddr(addr), .i_reqWr(wr), .i_reqEn(en), .i_reqLock(lk),
    .i_isBooted(booted), .i_isPaused(paused), .i_disableDrive(dis),
    .o_grant(grant_f), .o_ack(ack_f), .o_busy(busy_f),
    .io_memAddr(maddr_f), .io_memWr(mwr_f), .io_memEn(men_f));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int hm(input int m);
    return m == 0 ? 2 : 1;
  endfunction
  function automatic bit elig(input int c);
    bit ok;
    ok = !booted ? (c == 0) : paused ? (c == N - 1) : (c > 0 && c < N - 1);
    return ok && en[c];
  endfunction
  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mg[m] = -1;
      mp[m] = N - 1;
      mc[m] = 0;
    end
  endtask
  task automatic pick(input int m, input int excl);
    int w;
    w = -1;
    if (m == 0) begin
      for (int k = 1; k <= N; k++)
        if (w < 0 && elig((mp[m] + k) % N) && (mp[m] + k) % N != excl) w = (mp[m] + k) % N;
    end else begin
      for (int c = N - 1; c >= 0; c--)
        if (elig(c)) w = c;
    end
    mg[m] = w;
    mc[m] = 0;
    if (w >= 0) mp[m] = w;
  endtask
  task automatic step(input int m);
    int g, nc;
    bit other;
    g = mg[m];
    if (dis) return;
    if (g < 0 || !elig(g)) pick(m, -1);
    else if (!lk[g]) begin
      nc = (mc[m] + 1 > hm(m)) ? hm(m) : mc[m] + 1;
      other = 1'b0;
      for (int c = 0; c < N; c++)
        if (c != g && elig(c)) other = 1'b1;
      if (nc >= hm(m) && other) pick(m, m == 0 ? g : -1);
      else mc[m] = nc;
    end
  endtask
  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      int a;
      string p;
      logic [AW-1:0] ea;
      p = m == 0 ? "rr" : "fx";
      a = (mg[m] >= 0 && en[mg[m]] && !dis) ? mg[m] : -1;
      ea = '0;
      for (int c = 0; c < N; c++)
        if (c == a) ea = addr[c*AW +: AW];
      chk({p, "_grant"}, m == 0 ? grant_r : grant_f, mg[m] >= 0 ? 64'(1 << mg[m]) : 64'd0);
      chk({p, "_ack"}, m == 0 ? ack_r : ack_f, a >= 0 ? 64'(1 << a) : 64'd0);
      chk({p, "_busy"}, m == 0 ? busy_r : busy_f, 64'(mg[m] >= 0));
      if (!dis) begin
        chk({p, "_pin_en"}, m == 0 ? men_r : men_f, 64'(a >= 0));
        chk({p, "_pin_addr"}, m == 0 ? maddr_r : maddr_f, 64'(ea));
        chk({p, "_pin_wr"}, m == 0 ? mwr_r : mwr_f, a >= 0 ? 64'(wr[a]) : 64'd0);
      end
    end
  endtask
  task automatic cycle(input int n = 1);
    repeat (n) begin
      #1 check_all();
      @(posedge clk);
      step(0);
      step(1);
      #1;
      addr = {$urandom, $urandom};
      wr = N'($urandom);
    end
  endtask
  task automatic do_reset();
    dis = 1'b0;
    #2 rstn = 1'b0;
    #1 model_reset();
    check_all();
    @(posedge clk);
    #1 check_all();
    rstn = 1'b1;
  endtask
  initial begin
    logic [N-1:0] saved;
    int guard;
    rstn = 1'b0;
    addr = {$urandom, $urandom};
    wr = '0;
    en = 4'b1111;
    lk = '0;
    booted = 1'b0;
    paused = 1'b0;
    dis = 1'b0;
    model_reset();
    #12 check_all();
    rstn = 1'b1;
    cycle();
    chk("boot_grant", grant_r, 64'b0001);
    cycle(4);
    booted = 1'b1;
    en = 4'b0110;
    cycle(10);
    lk = 4'b0010;
    cycle(5);
    lk = '0;
    cycle(4);
    guard = 0;
    while (grant_r != 4'b0010 && guard < 6) begin
      cycle();
      guard++;
    end
    chk("lock_setup", grant_r, 64'b0010);
    lk = 4'b0010;
    cycle();
    paused = 1'b1;
    en = 4'b1110;
    cycle();
    chk("pause_jtag", grant_r, 64'b1000);
    lk = '0;
    cycle(2);
    paused = 1'b0;
    en = 4'b0110;
    cycle(3);
    saved = grant_r;
    dis = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("dis_hold", grant_r, 64'(saved));
      chk("dis_ack", ack_r, 64'd0);
    end
    dis = 1'b0;
    cycle(3);
    en = 4'b0100;
    cycle(2);
    en = 4'b0110;
    cycle(3);
    do_reset();
    cycle(2);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(2) == 0) en = N'($urandom);
      lk = ($urandom_range(3) == 0) ? N'($urandom) : '0;
      if ($urandom_range(7) == 0) booted = $urandom_range(15) != 0;
      if ($urandom_range(7) == 0) paused = $urandom_range(4) == 0;
      dis = $urandom_range(11) == 0;
      if ($urandom_range(399) == 0) do_reset();
      cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
